// File: rtl/stitch_pipeline_elastic_if.sv
// Handshake bundle for the elastic stitched pipeline.
// master: the environment (drives in_valid/in_data/flush, consumes with out_ready).
// slave : the pipeline (drives in_ready, out_valid/out_data and occupancy).
//   in_valid/in_ready/in_data : upstream valid/ready transfer
//   flush                     : drop every in-flight word at the next edge
//   out_valid/out_ready/out_data : downstream valid/ready transfer
//   occupancy                 : number of ranks currently holding a word
interface stitch_pipeline_elastic_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_STAGES = 2
);
  localparam int unsigned OCC_W = $clog2(NUM_STAGES + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/stitch_pipeline_elastic.sv
// Elastic stitched pipeline shell: NUM_STAGES register ranks move a DATA_W
// payload from input to output with a valid flag per rank, valid/ready
// backpressure, bubble collapse, synchronous flush and occupancy reporting.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : stitch_pipeline_elastic_if.slave (in/out handshakes, flush, occupancy)
module stitch_pipeline_elastic #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       NUM_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  stitch_pipeline_elastic_if.slave      bus
);
  localparam int unsigned OCC_W = $clog2(NUM_STAGES + 1);

  // Rank state: index 1 is nearest the input, NUM_STAGES drives the output.
  logic [NUM_STAGES:1] valid_q;
  logic [DATA_W-1:0]   data_q [1:NUM_STAGES];
  logic [OCC_W-1:0]    occ_q;

  // Per-rank advance enables and the source each rank loads from.
  logic [NUM_STAGES:1]   adv;
  logic [NUM_STAGES-1:0] src_valid;
  logic [DATA_W-1:0]     src_data [0:NUM_STAGES-1];

  logic in_ready_c;
  logic in_xfer;
  logic out_xfer;

  // Advance chain: a rank may move when it is empty or its successor moves,
  // so bubbles anywhere in the pipe are squeezed out under backpressure.
  always_comb begin
    adv = '0;
    adv[NUM_STAGES] = !valid_q[NUM_STAGES] || bus.out_ready;
    for (int i = int'(NUM_STAGES) - 1; i >= 1; i--) begin
      adv[i] = !valid_q[i] || adv[i+1];
    end
  end

  // Source of each rank: rank 0 is the input port, rank i feeds rank i+1.
  always_comb begin
    src_valid    = '0;
    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.in_data;
    for (int i = 1; i < int'(NUM_STAGES); i++) begin
      src_valid[i] = valid_q[i];
      src_data[i]  = data_q[i];
    end
  end

  // Flush and reset both block the input so a word is never half-accepted.
  always_comb begin
    in_ready_c = adv[1] && !bus.flush && !rst;
    in_xfer    = bus.in_valid && in_ready_c;
    out_xfer   = valid_q[NUM_STAGES] && bus.out_ready;
  end

  // Rank registers. Data only loads with a valid word, so bubbles keep stale
  // data; flush clears valids but leaves data untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 1; i <= int'(NUM_STAGES); i++) begin
        data_q[i] <= RESET_DATA;
      end
    end else if (bus.flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 1; i <= int'(NUM_STAGES); i++) begin
        if (adv[i]) begin
          valid_q[i] <= src_valid[i-1];
          if (src_valid[i-1]) begin
            data_q[i] <= src_data[i-1];
          end
        end
      end
    end
  end

  // Occupancy counter tracks popcount(valid_q) from the transfer events.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      occ_q <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q[NUM_STAGES];
  assign bus.out_data  = data_q[NUM_STAGES];
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_stitch_pipeline_elastic.sv
// Bench for stitch_pipeline_elastic: vector table on a 2-rank build, hand
// sequences on 1- and 4-rank builds, then a random valid/ready scoreboard.
module tb_stitch_pipeline_elastic;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2, rst4;
  bit   sb_on = 1'b0;

  stitch_pipeline_elastic_if #(.DATA_W(DATA_W), .NUM_STAGES(1)) bus1 ();
  stitch_pipeline_elastic_if #(.DATA_W(DATA_W), .NUM_STAGES(2)) bus2 ();
  stitch_pipeline_elastic_if #(.DATA_W(DATA_W), .NUM_STAGES(4)) bus4 ();

  stitch_pipeline_elastic #(.DATA_W(DATA_W), .NUM_STAGES(1), .RESET_DATA('0)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1));
  stitch_pipeline_elastic #(.DATA_W(DATA_W), .NUM_STAGES(2), .RESET_DATA('0)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2));
  stitch_pipeline_elastic #(.DATA_W(DATA_W), .NUM_STAGES(4), .RESET_DATA('0)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        flush;
    logic        out_ready;
    logic        chk;          // state known: compare registered outputs
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [31:0] exp_out_data;
    logic        chk_data;
    logic [1:0]  exp_occ;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic iv, input logic [31:0] d, input logic fl,
                     input logic ordy, input logic c, input logic ir, input logic ov,
                     input logic [31:0] od, input logic cd, input logic [1:0] occ);
    vec_t v;
    v = '{r, iv, d, fl, ordy, c, ir, ov, od, cd, occ};
    tbl.push_back(v);
  endtask

  // Scoreboards: inputs/outputs sampled on the falling edge, where the
  // handshake that completes at the next rising edge is stable.
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] q4[$];

  always @(negedge clk) if (sb_on) begin
    check("sb1 occupancy", 64'(bus1.occupancy), 64'(q1.size()));
    if (bus1.out_valid && bus1.out_ready) begin
      check("sb1 nonempty", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) check("sb1 data", 64'(bus1.out_data), 64'(q1.pop_front()));
    end
    if (bus1.in_valid && bus1.in_ready) q1.push_back(bus1.in_data);
  end

  always @(negedge clk) if (sb_on) begin
    check("sb2 occupancy", 64'(bus2.occupancy), 64'(q2.size()));
    if (bus2.out_valid && bus2.out_ready) begin
      check("sb2 nonempty", 64'(q2.size() != 0), 64'd1);
      if (q2.size() != 0) check("sb2 data", 64'(bus2.out_data), 64'(q2.pop_front()));
    end
    if (bus2.in_valid && bus2.in_ready) q2.push_back(bus2.in_data);
  end

  always @(negedge clk) if (sb_on) begin
    check("sb4 occupancy", 64'(bus4.occupancy), 64'(q4.size()));
    if (bus4.out_valid && bus4.out_ready) begin
      check("sb4 nonempty", 64'(q4.size() != 0), 64'd1);
      if (q4.size() != 0) check("sb4 data", 64'(bus4.out_data), 64'(q4.pop_front()));
    end
    if (bus4.in_valid && bus4.in_ready) q4.push_back(bus4.in_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst1 = 1'b1; rst4 = 1'b1; rst2 = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.flush = 1'b0; bus1.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.flush = 1'b0; bus4.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.flush = 1'b0; bus2.out_ready = 1'b0;

    // rst iv data fl ordy | chk ir ov out_data cd occ   (expected = state before the edge)
    add(1, 1, 32'h55, 0, 0,  0, 0, 0, 32'h0,  0, 0);  // reset, state unknown
    add(1, 1, 32'h55, 0, 0,  1, 0, 0, 32'h0,  1, 0);  // reset held
    add(0, 1, 32'h7,  0, 1,  1, 1, 0, 32'h0,  1, 0);  // stream
    add(0, 1, 32'h8,  0, 1,  1, 1, 0, 32'h0,  1, 1);
    add(0, 1, 32'h9,  0, 1,  1, 1, 1, 32'h7,  1, 2);
    add(0, 0, 32'h0,  0, 1,  1, 1, 1, 32'h8,  1, 2);
    add(0, 0, 32'h0,  0, 1,  1, 1, 1, 32'h9,  1, 1);
    add(0, 1, 32'hA,  0, 0,  1, 1, 0, 32'h9,  1, 0);  // backpressure
    add(0, 1, 32'hB,  0, 0,  1, 1, 0, 32'h9,  1, 1);
    add(0, 1, 32'hC,  0, 0,  1, 0, 1, 32'hA,  1, 2);
    add(0, 1, 32'hC,  0, 1,  1, 1, 1, 32'hA,  1, 2);
    add(0, 0, 32'h0,  0, 1,  1, 1, 1, 32'hB,  1, 2);
    add(0, 0, 32'h0,  0, 1,  1, 1, 1, 32'hC,  1, 1);
    add(0, 1, 32'h1,  0, 0,  1, 1, 0, 32'hC,  1, 0);  // bubble collapse
    add(0, 0, 32'h0,  0, 0,  1, 1, 0, 32'hC,  1, 1);
    add(0, 1, 32'h2,  0, 0,  1, 1, 1, 32'h1,  1, 1);
    add(0, 1, 32'h3,  0, 0,  1, 0, 1, 32'h1,  1, 2);
    add(0, 1, 32'h3,  1, 0,  1, 0, 1, 32'h1,  1, 2);  // flush while full
    add(0, 0, 32'h0,  0, 0,  1, 1, 0, 32'h1,  1, 0);
    add(0, 1, 32'h11, 0, 1,  1, 1, 0, 32'h1,  1, 0);
    add(0, 1, 32'h12, 0, 1,  1, 1, 0, 32'h1,  1, 1);
    add(0, 1, 32'h13, 1, 1,  1, 0, 1, 32'h11, 1, 2);  // flush with output transfer
    add(0, 0, 32'h0,  0, 1,  1, 1, 0, 32'h11, 1, 0);
    add(0, 1, 32'h21, 0, 0,  1, 1, 0, 32'h11, 1, 0);
    add(0, 1, 32'h22, 0, 0,  1, 1, 0, 32'h11, 1, 1);
    add(1, 1, 32'h23, 0, 0,  1, 0, 1, 32'h21, 1, 2);  // reset mid-stream
    add(0, 0, 32'h0,  0, 1,  1, 1, 0, 32'h0,  1, 0);

    foreach (tbl[i]) begin
      rst2 = tbl[i].rst;
      bus2.in_valid  = tbl[i].in_valid;
      bus2.in_data   = tbl[i].in_data;
      bus2.flush     = tbl[i].flush;
      bus2.out_ready = tbl[i].out_ready;
      @(negedge clk);
      check($sformatf("row%0d in_ready", i), 64'(bus2.in_ready), 64'(tbl[i].exp_in_ready));
      if (tbl[i].chk) begin
        check($sformatf("row%0d out_valid", i), 64'(bus2.out_valid), 64'(tbl[i].exp_out_valid));
        check($sformatf("row%0d occupancy", i), 64'(bus2.occupancy), 64'(tbl[i].exp_occ));
        if (tbl[i].chk_data)
          check($sformatf("row%0d out_data", i), 64'(bus2.out_data), 64'(tbl[i].exp_out_data));
      end
      step();
    end
    bus2.in_valid = 1'b0; bus2.flush = 1'b0;

    // Single-rank build: zero added cycles, in_ready = !v | out_ready.
    rst1 = 1'b0; bus1.in_valid = 1'b1; bus1.in_data = 32'h31; bus1.out_ready = 1'b0;
    @(negedge clk);
    check("n1 empty in_ready", 64'(bus1.in_ready), 64'd1);
    check("n1 empty out_valid", 64'(bus1.out_valid), 64'd0);
    check("n1 empty occupancy", 64'(bus1.occupancy), 64'd0);
    check("n1 reset out_data", 64'(bus1.out_data), 64'd0);
    step();
    bus1.in_data = 32'h32;
    @(negedge clk);
    check("n1 full out_valid", 64'(bus1.out_valid), 64'd1);
    check("n1 full out_data", 64'(bus1.out_data), 64'h31);
    check("n1 full occupancy", 64'(bus1.occupancy), 64'd1);
    check("n1 full in_ready", 64'(bus1.in_ready), 64'd0);
    step();
    bus1.out_ready = 1'b1;
    @(negedge clk);
    check("n1 full in_ready ordy", 64'(bus1.in_ready), 64'd1);
    step();
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("n1 second out_data", 64'(bus1.out_data), 64'h32);
    check("n1 second occupancy", 64'(bus1.occupancy), 64'd1);
    step();
    @(negedge clk);
    check("n1 drained out_valid", 64'(bus1.out_valid), 64'd0);
    check("n1 drained occupancy", 64'(bus1.occupancy), 64'd0);
    step();

    // Four-rank build: latency of three edges after acceptance, fill, reset.
    rst4 = 1'b0; bus4.in_valid = 1'b1; bus4.in_data = 32'h41; bus4.out_ready = 1'b1;
    @(negedge clk);
    check("n4 empty in_ready", 64'(bus4.in_ready), 64'd1);
    check("n4 empty occupancy", 64'(bus4.occupancy), 64'd0);
    step();
    bus4.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("n4 latency%0d out_valid", c), 64'(bus4.out_valid), 64'd0);
      check($sformatf("n4 latency%0d occupancy", c), 64'(bus4.occupancy), 64'd1);
      step();
    end
    @(negedge clk);
    check("n4 arrive out_valid", 64'(bus4.out_valid), 64'd1);
    check("n4 arrive out_data", 64'(bus4.out_data), 64'h41);
    step();
    bus4.out_ready = 1'b0; bus4.in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus4.in_data = 32'h50 + 32'(c);
      step();
    end
    bus4.in_data = 32'h54;
    @(negedge clk);
    check("n4 full occupancy", 64'(bus4.occupancy), 64'd4);
    check("n4 full in_ready", 64'(bus4.in_ready), 64'd0);
    check("n4 full out_data", 64'(bus4.out_data), 64'h50);
    step();
    rst4 = 1'b1;
    @(negedge clk);
    check("n4 rst in_ready", 64'(bus4.in_ready), 64'd0);
    step();
    rst4 = 1'b0; bus4.in_valid = 1'b0;
    @(negedge clk);
    check("n4 post-rst out_valid", 64'(bus4.out_valid), 64'd0);
    check("n4 post-rst occupancy", 64'(bus4.occupancy), 64'd0);
    check("n4 post-rst out_data", 64'(bus4.out_data), 64'd0);
    step();

    // Random valid/ready traffic on all three builds, then drain.
    sb_on = 1'b1;
    for (int c = 0; c < 400; c++) begin
      bus1.in_valid = 1'($urandom_range(0, 1)); bus1.in_data = $urandom;
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      bus2.in_valid = 1'($urandom_range(0, 1)); bus2.in_data = $urandom;
      bus2.out_ready = ($urandom_range(0, 3) != 0);
      bus4.in_valid = 1'($urandom_range(0, 1)); bus4.in_data = $urandom;
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    sb_on = 1'b0;
    check("sb1 drained", 64'(q1.size()), 64'd0);
    check("sb2 drained", 64'(q2.size()), 64'd0);
    check("sb4 drained", 64'(q4.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
